// File: rtl/text_blitter.sv
// Glyph blitter: draws one GLYPH_W x GLYPH_H character from a row-major glyph
// ROM into a line-organised VRAM using read-modify-write per glyph row.
// Each row costs ROM -> RD -> WR, so a full glyph with a permanent grant is
// 3*GLYPH_H cycles plus the DONE cycle.
module text_blitter #(
  parameter int LINE_W     = 640,
  parameter int Y_W        = 9,
  parameter int GLYPH_W    = 7,
  parameter int GLYPH_H    = 10,
  parameter int NUM_GLYPHS = 39,
  parameter int BLANK_CODE = 38
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        let_code,
  input  logic [9:0]        x_pos,
  input  logic [Y_W-1:0]    y_pos,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              let_done,
  output logic [8:0]        rom_addr,
  input  logic [GLYPH_W-1:0] rom_data,
  output logic              vram_req,
  input  logic              vram_turn,
  output logic [Y_W-1:0]    line_addr,
  input  logic [LINE_W-1:0] line_from_vram,
  output logic              activate_write,
  output logic [LINE_W-1:0] line_to_vram
);

  localparam int ROW_W = $clog2(GLYPH_H + 1);
  // Window template: GLYPH_W ones at screen column 0 (line MSB), shifted right by x.
  localparam logic [LINE_W-1:0] WIN = {{GLYPH_W{1'b1}}, {(LINE_W-GLYPH_W){1'b0}}};

  typedef enum logic [2:0] {IDLE, ROM, RD, WR, DONE} state_t;

  state_t               state, state_nx;
  logic [5:0]           lat_let;
  logic [9:0]           lat_x;
  logic [1:0]           lat_mode;
  logic [ROW_W-1:0]     row;
  logic [GLYPH_W-1:0]   glyph_row;
  logic                 accept, last_row, blank;
  logic [LINE_W-1:0]    win_mask, glyph_line, mode_line, new_line;

  assign accept   = (state == IDLE) && start;
  assign last_row = (row == ROW_W'(GLYPH_H - 1));
  // Out-of-range codes render like the blank glyph rather than reading garbage.
  assign blank    = (lat_let == 6'(BLANK_CODE)) || ({1'b0, lat_let} >= 7'(NUM_GLYPHS));

  // Shifting past the line end drops columns, which is exactly the right-edge clip.
  assign win_mask   = WIN >> lat_x;
  assign glyph_line = {glyph_row, {(LINE_W-GLYPH_W){1'b0}}} >> lat_x;
  assign new_line   = (line_from_vram & ~win_mask) | (mode_line & win_mask);

  // Per-mode combination of old line and glyph; masking to the window happens above.
  always_comb begin
    mode_line = glyph_line;
    case (lat_mode)
      2'd0:    mode_line = glyph_line;
      2'd1:    mode_line = line_from_vram | glyph_line;
      2'd2:    mode_line = ~glyph_line;
      default: mode_line = line_from_vram ^ glyph_line;
    endcase
  end

  // State register; async reset lands in IDLE immediately, aborting any draw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and state-decoded outputs; vram_turn only matters in RD/WR.
  always_comb begin
    state_nx       = state;
    busy           = 1'b1;
    let_done       = 1'b0;
    vram_req       = 1'b0;
    activate_write = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ROM;
      end
      ROM:  state_nx = RD;
      RD: begin
        vram_req = 1'b1;
        if (vram_turn) state_nx = WR;
      end
      WR: begin
        vram_req       = 1'b1;
        activate_write = 1'b1;
        if (vram_turn) state_nx = last_row ? DONE : ROM;
      end
      DONE: begin
        let_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: request latch, row/address stepping, glyph capture, line merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_let      <= '0;
      lat_x        <= '0;
      lat_mode     <= '0;
      row          <= '0;
      rom_addr     <= '0;
      line_addr    <= '0;
      glyph_row    <= '0;
      line_to_vram <= '0;
    end else begin
      if (accept) begin
        lat_let   <= let_code;
        lat_x     <= x_pos;
        lat_mode  <= mode;
        row       <= '0;
        rom_addr  <= 9'(let_code);
        line_addr <= y_pos;
      end
      if (state == ROM)
        glyph_row <= blank ? '0 : rom_data;
      if (state == RD && vram_turn)
        line_to_vram <= new_line;
      if (state == WR && vram_turn && !last_row) begin
        row       <= row + ROW_W'(1);
        rom_addr  <= 9'(int'(lat_let) + (int'(row) + 1) * NUM_GLYPHS);
        line_addr <= line_addr + Y_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_text_blitter.sv
// Directed bench for text_blitter: behavioural ROM and VRAM models, one task
// per scenario, expected lines built column by column from the pixel mapping.
module tb_text_blitter;

  localparam int LW = 640;

  logic          clk = 0, rst_n = 0, start = 0;
  logic [5:0]    let_code = '0;
  logic [9:0]    x_pos = '0;
  logic [8:0]    y_pos = '0;
  logic [1:0]    mode = '0;
  logic          busy, let_done, vram_req, activate_write, vram_turn;
  logic [8:0]    rom_addr, line_addr;
  logic [6:0]    rom_data;
  logic [LW-1:0] line_from_vram, line_to_vram;

  logic [LW-1:0] vram [0:511];
  logic [LW-1:0] fill_pat = '0;
  logic          prep_en = 0, gnt_all = 1;
  logic [1:0]    gcnt = '0;
  logic [8:0]    wr_log [0:63];
  int            wr_cnt = 0, done_cnt = 0;
  int            n_vec = 0, n_err = 0;

  text_blitter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .let_code(let_code), .x_pos(x_pos),
    .y_pos(y_pos), .mode(mode), .busy(busy), .let_done(let_done), .rom_addr(rom_addr),
    .rom_data(rom_data), .vram_req(vram_req), .vram_turn(vram_turn), .line_addr(line_addr),
    .line_from_vram(line_from_vram), .activate_write(activate_write), .line_to_vram(line_to_vram)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] rom_fn(input logic [8:0] a);
    logic [8:0] t;
    t = a * 9'd53 + 9'd17;
    return t[6:0] ^ t[8:2];
  endfunction

  function automatic logic [6:0] grow(input int l, input int r);
    if (l == 38 || l >= 39) return 7'd0;
    return rom_fn(9'(l + r * 39));
  endfunction

  // Reference pixel placement: glyph bit 6-j lands on column x+j, line bit 639-column.
  function automatic logic [LW-1:0] blit(input logic [LW-1:0] old, input logic [6:0] g,
                                          input int x, input logic [1:0] m);
    logic [LW-1:0] r;
    int c;
    logic gb;
    r = old;
    for (int j = 0; j < 7; j++) begin
      c  = x + j;
      gb = g[6-j];
      if (c < LW) begin
        case (m)
          2'd0: r[LW-1-c] = gb;
          2'd1: r[LW-1-c] = old[LW-1-c] | gb;
          2'd2: r[LW-1-c] = ~gb;
          default: r[LW-1-c] = old[LW-1-c] ^ gb;
        endcase
      end
    end
    return r;
  endfunction

  assign rom_data       = rom_fn(rom_addr);
  assign vram_turn      = gnt_all | (gcnt == 2'd3);
  assign line_from_vram = vram[line_addr];

  always @(posedge clk) gcnt <= gcnt + 2'd1;

  // VRAM write port and event logs.
  always @(posedge clk) begin
    if (prep_en) begin
      for (int i = 0; i < 512; i++) vram[i] <= fill_pat;
      wr_cnt   <= 0;
      done_cnt <= 0;
    end else begin
      if (activate_write && vram_turn) begin
        vram[line_addr] <= line_to_vram;
        if (wr_cnt < 64) wr_log[wr_cnt] <= line_addr;
        wr_cnt <= wr_cnt + 1;
      end
      if (let_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic prep(input logic [LW-1:0] pat);
    @(negedge clk);
    fill_pat = pat;
    prep_en  = 1;
    @(negedge clk);
    prep_en  = 0;
  endtask

  // Issue one draw; inputs are scrambled after acceptance to prove they are latched.
  // lat counts cycles with the acceptance cycle as 0; -1 means no let_done seen.
  task automatic draw(input logic [5:0] l, input logic [9:0] x, input logic [8:0] y,
                      input logic [1:0] m, output int lat);
    @(negedge clk);
    let_code = l; x_pos = x; y_pos = y; mode = m; start = 1;
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      start = 0;
      let_code = l ^ 6'h15; x_pos = x ^ 10'h155; y_pos = ~y; mode = ~m;
      if (let_done) begin lat = c; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (let_done !== 1'b0) begin n_err++; $display("FAIL reset_let_done: got %b want 0", let_done); end
    n_vec++; if (vram_req !== 1'b0) begin n_err++; $display("FAIL reset_vram_req: got %b want 0", vram_req); end
    n_vec++; if (activate_write !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b want 0", activate_write); end
    n_vec++; if (rom_addr !== 9'd0) begin n_err++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    n_vec++; if (line_addr !== 9'd0) begin n_err++; $display("FAIL reset_line_addr: got %0d want 0", line_addr); end
    n_vec++; if (line_to_vram !== '0) begin n_err++; $display("FAIL reset_line_to_vram: got %h want 0", line_to_vram); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk); #1;
    n_vec++; if (vram_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: req %b busy %b want 0 0", vram_req, busy); end
  endtask

  task automatic test_opaque();
    int lat;
    logic [LW-1:0] e;
    prep('1);
    draw(6'd0, 10'd0, 9'd0, 2'd0, lat);
    n_vec++; if (lat !== 31) begin n_err++; $display("FAIL opaque_latency: got %0d want 31", lat); end
    n_vec++; if (wr_cnt !== 10) begin n_err++; $display("FAIL opaque_writes: got %0d want 10", wr_cnt); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL opaque_done: got %0d want 1", done_cnt); end
    for (int r = 0; r < 10; r++) begin
      e = blit('1, grow(0, r), 0, 2'd0);
      n_vec++; if (vram[r] !== e) begin n_err++; $display("FAIL opaque_row%0d: got %h want %h", r, vram[r], e); end
    end
    e = '1;
    n_vec++; if (vram[10] !== e) begin n_err++; $display("FAIL opaque_row10_untouched: got %h want all ones", vram[10]); end
  endtask

  task automatic test_clip();
    int lat;
    logic [LW-1:0] pat, e;
    pat = {160{4'h5}};
    prep(pat);
    draw(6'd5, 10'd636, 9'd20, 2'd1, lat);
    n_vec++; if (lat !== 31) begin n_err++; $display("FAIL clip_latency: got %0d want 31", lat); end
    for (int r = 0; r < 10; r++) begin
      e = blit(pat, grow(5, r), 636, 2'd1);
      n_vec++; if (vram[20+r] !== e) begin n_err++; $display("FAIL clip_row%0d: got %h want %h", r, vram[20+r], e); end
    end
    n_vec++; if (vram[20][LW-1:4] !== pat[LW-1:4]) begin n_err++; $display("FAIL clip_outside: got %h want %h", vram[20][LW-1:4], pat[LW-1:4]); end
  endtask

  task automatic test_blank();
    int lat;
    logic [LW-1:0] e;
    prep('1);
    draw(6'd38, 10'd100, 9'd40, 2'd0, lat);
    n_vec++; if (lat !== 31) begin n_err++; $display("FAIL blank_latency: got %0d want 31", lat); end
    n_vec++; if (done_cnt !== 1 || let_done !== 1'b0) begin n_err++; $display("FAIL blank_done_pulse: count %0d level %b want 1 0", done_cnt, let_done); end
    for (int r = 0; r < 10; r++) begin
      e = blit('1, 7'd0, 100, 2'd0);
      n_vec++; if (vram[40+r] !== e) begin n_err++; $display("FAIL blank_row%0d: got %h want %h", r, vram[40+r], e); end
    end
    n_vec++; if (vram[40][539:533] !== 7'd0) begin n_err++; $display("FAIL blank_window: got %b want 0", vram[40][539:533]); end
  endtask

  task automatic test_wrap_busy();
    int lat, bad_busy;
    logic [LW-1:0] e;
    prep('1);
    @(negedge clk);
    let_code = 6'd3; x_pos = 10'd10; y_pos = 9'd508; mode = 2'd3; start = 1;
    lat = -1; bad_busy = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (!busy) bad_busy++;
      if (let_done) begin lat = c; start = 0; break; end
    end
    start = 0;
    repeat (5) @(posedge clk); #1;
    n_vec++; if (lat !== 31) begin n_err++; $display("FAIL wrap_latency: got %0d want 31", lat); end
    n_vec++; if (bad_busy !== 0) begin n_err++; $display("FAIL wrap_busy_low: got %0d cycles want 0", bad_busy); end
    n_vec++; if (done_cnt !== 1 || wr_cnt !== 10 || busy !== 1'b0) begin n_err++; $display("FAIL wrap_single_draw: done %0d writes %0d busy %b want 1 10 0", done_cnt, wr_cnt, busy); end
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (wr_log[i] !== 9'((508 + i) % 512)) begin n_err++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, wr_log[i], (508 + i) % 512); end
    end
    e = blit('1, grow(3, 3), 10, 2'd3);
    n_vec++; if (vram[511] !== e) begin n_err++; $display("FAIL wrap_row511: got %h want %h", vram[511], e); end
    e = blit('1, grow(3, 4), 10, 2'd3);
    n_vec++; if (vram[0] !== e) begin n_err++; $display("FAIL wrap_row0: got %h want %h", vram[0], e); end
  endtask

  task automatic test_stall();
    int lat;
    logic [LW-1:0] pat, e;
    pat = {20{32'hDEADBEEF}};
    prep(pat);
    gnt_all = 0;
    draw(6'd12, 10'd300, 9'd100, 2'd2, lat);
    gnt_all = 1;
    n_vec++; if (!(lat > 31)) begin n_err++; $display("FAIL stall_latency: got %0d want >31", lat); end
    n_vec++; if (wr_cnt !== 10) begin n_err++; $display("FAIL stall_writes: got %0d want 10", wr_cnt); end
    for (int r = 0; r < 10; r++) begin
      e = blit(pat, grow(12, r), 300, 2'd2);
      n_vec++; if (vram[100+r] !== e) begin n_err++; $display("FAIL stall_row%0d: got %h want %h", r, vram[100+r], e); end
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit found;
    logic [LW-1:0] e;
    prep('1);
    @(negedge clk);
    let_code = 6'd7; x_pos = 10'd0; y_pos = 9'd60; mode = 2'd0; start = 1;
    @(posedge clk); #1;
    start = 0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (activate_write && wr_cnt == 3) begin found = 1; break; end
      @(posedge clk); #1;
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL abort_reach_wr4: got %b want 1", found); end
    rst_n = 0;
    #1;
    n_vec++; if (activate_write !== 1'b0 || busy !== 1'b0 || vram_req !== 1'b0) begin n_err++; $display("FAIL abort_immediate: wr %b busy %b req %b want 0 0 0", activate_write, busy, vram_req); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (40) @(posedge clk); #1;
    n_vec++; if (wr_cnt !== 3) begin n_err++; $display("FAIL abort_writes: got %0d want 3", wr_cnt); end
    n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
    draw(6'd45, 10'd200, 9'd70, 2'd0, lat);
    n_vec++; if (lat !== 31) begin n_err++; $display("FAIL invalid_latency: got %0d want 31", lat); end
    for (int r = 0; r < 10; r++) begin
      e = blit('1, grow(45, r), 200, 2'd0);
      n_vec++; if (vram[70+r] !== e) begin n_err++; $display("FAIL invalid_row%0d: got %h want %h", r, vram[70+r], e); end
    end
  endtask

  initial begin
    test_reset();
    test_opaque();
    test_clip();
    test_blank();
    test_wrap_busy();
    test_stall();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_blitter.md
TEXT_BLITTER -- requirements
Module: text_blitter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- LINE_W, 640, VRAM line width in pixels.
- Y_W, 9, VRAM line address width.
- GLYPH_W, 7, glyph width in pixels.
- GLYPH_H, 10, glyph height in rows.
- NUM_GLYPHS, 39, number of glyph codes.
- BLANK_CODE, 38, code that renders as all-zero.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, the block's single clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- start, in, 1, draw request.
- let, in, 6, glyph code.
- x_pos, in, 10, left pixel column.
- y_pos, in, Y_W, top line.
- mode, in, 2, 0 = opaque, 1 = transparent OR, 2 = inverted opaque, 3 = XOR.
- busy, out, 1, a draw is in progress.
- let_done, out, 1, one-cycle completion pulse.
- rom_addr, out, 9, glyph ROM address.
- rom_data, in, GLYPH_W, ROM row data; 1-cycle read latency.
- vram_req, out, 1, requests VRAM access.
- vram_turn, in, 1, one-cycle access grant.
- line_addr, out, Y_W, VRAM line being accessed.
- line_from_vram, in, LINE_W, read data, valid while vram_turn=1 in the read phase.
- activate_write, out, 1, write strobe.
- line_to_vram, out, LINE_W, write data.

Function
REQ-003 start SHALL be accepted only in IDLE; let, x_pos, y_pos and mode SHALL be latched on acceptance; start while busy=1 SHALL be ignored.
REQ-004 The FSM states SHALL be IDLE, ROM, RD, WR, DONE.
- IDLE->ROM on start.
- ROM->RD after exactly one cycle.
- RD->WR on vram_turn.
- WR->ROM on vram_turn when row<GLYPH_H-1; WR->DONE on vram_turn when row=GLYPH_H-1.
- DONE->IDLE after one cycle.
REQ-005 rom_addr SHALL equal latched_let + row*NUM_GLYPHS, registered, stable throughout ROM; rom_data SHALL be captured at the end of ROM.
REQ-006 Latched glyph row data SHALL be forced to 0 when latched_let = BLANK_CODE or latched_let >= NUM_GLYPHS.
REQ-007 line_addr SHALL equal latched y_pos + row, truncated to Y_W bits (wraps modulo 2^Y_W).
REQ-008 vram_req SHALL be 1 in RD and WR and 0 otherwise; activate_write SHALL be 1 only in WR.
REQ-009 line_from_vram SHALL be captured on the vram_turn cycle in RD; line_to_vram SHALL be registered, computed from that capture, and held constant throughout WR.
REQ-010 Pixel mapping:
- Screen column c SHALL map to line bit LINE_W-1-c.
- Glyph bit GLYPH_W-1 SHALL be the leftmost pixel, at column x_pos.
REQ-011 Mode behaviour in the glyph window:
- Opaque: window bits = glyph.
- Transparent: window bits = old | glyph.
- Inverted: window bits = ~glyph.
- XOR: window bits = old ^ glyph.
- All bits outside the window SHALL be unchanged.
REQ-012 Clipping: glyph columns at x >= LINE_W SHALL be dropped; if x_pos >= LINE_W, every row SHALL still be read and written back unchanged.
REQ-013 let_done SHALL pulse high for exactly the DONE cycle; busy SHALL be 1 in every state except IDLE.
REQ-014 With a permanent grant, a glyph SHALL take 3*GLYPH_H+1 cycles from start acceptance to let_done.
REQ-015 vram_turn SHALL be ignored in IDLE, ROM and DONE.

Reset
REQ-016 When rst_n=0, the block SHALL immediately be in IDLE with row=0 and busy, let_done, vram_req and activate_write all 0; rom_addr, line_addr and line_to_vram SHALL reset to 0.
REQ-017 A reset mid-draw SHALL abort the draw with no further write strobes and no let_done pulse.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Opaque draw: let=0, x=0, y=0, mode=0, vram all-ones, grant always high -> rows 0..9 written; bits 639:633 equal the ROM row; all other bits 1; let_done at cycle 31.
- Right-edge clip: let=5, x=636, mode=1 -> only bits 3:0 change, taking glyph bits 6:3 ORed in.
- Blank glyph: let=38, mode=0, vram all-ones -> 7-bit window cleared on all 10 rows; let_done pulse.
- Line wrap and busy: y=508 -> line_addr sequence 508..511, 0..5; start held while busy is ignored.
- Reset and invalid code: rst_n low during the 4th WR -> no further activate_write and no let_done; let=45 -> draws as blank.
